// File: rtl/cipher_uart_tx_if.sv
// Byte ingress from the cipher core plus serial line and status back out of the UART egress stage.
// The master modport is the cipher core/firmware side; the slave modport is the transmitter.
interface cipher_uart_tx_if #(
   parameter int DEPTH_LOG2 = 2
);
   logic [7:0]          in_data;
   logic                in_valid;
   logic                clr_overflow;
   logic                tx;
   logic                busy;
   logic [DEPTH_LOG2:0] fifo_level;
   logic                overflow;

   modport master (
      output in_data, in_valid, clr_overflow,
      input  tx, busy, fifo_level, overflow
   );

   modport slave (
      input  in_data, in_valid, clr_overflow,
      output tx, busy, fifo_level, overflow
   );
endinterface

// File: rtl/cipher_uart_tx.sv
// Ciphertext byte FIFO drained as 8N1 UART frames; tx falls 2 edges after an idle in_valid strobe.
// No backpressure: writes to a full FIFO are dropped and latch the sticky overflow flag.
module cipher_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DEPTH_LOG2   = 2
) (
   input logic             clk,
   input logic             rst,
   cipher_uart_tx_if.slave bus
);
   localparam int                  DEPTH      = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [7:0]          BAUD_LAST  = 8'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t                state;
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   level;
   logic [7:0]            shift;
   logic [7:0]            baud_cnt;
   logic [2:0]            bit_cnt;
   logic                  tx_r;
   logic                  busy_r;
   logic                  overflow_r;
   logic                  pop;
   logic                  full;
   logic                  wr_en;
   logic                  drop;
   logic                  baud_done;

   // A pop frees a slot in the same cycle, so a write into a full FIFO is still accepted then.
   always_comb begin
      pop       = (state == IDLE) && (level != '0);
      full      = (level == FULL_LEVEL);
      wr_en     = bus.in_valid && (!full || pop);
      drop      = bus.in_valid && full && !pop;
      baud_done = (baud_cnt == BAUD_LAST);
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= bus.in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         overflow_r <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         level <= level + {{DEPTH_LOG2{1'b0}}, wr_en} - {{DEPTH_LOG2{1'b0}}, pop};
         if (drop) begin
            overflow_r <= 1'b1;
         end else if (bus.clr_overflow) begin
            overflow_r <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         shift    <= '0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         tx_r     <= 1'b1;
         busy_r   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               tx_r <= 1'b1;
               if (pop) begin
                  shift    <= mem[rd_ptr];
                  bit_cnt  <= '0;
                  baud_cnt <= '0;
                  tx_r     <= 1'b0;
                  busy_r   <= 1'b1;
                  state    <= START;
               end
            end
            START: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  tx_r     <= shift[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 8'd1;
               end
            end
            DATA: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
                     tx_r  <= 1'b1;
                     state <= STOP;
                  end else begin
                     // tx takes the next bit directly so the line changes on the same edge as the shift.
                     shift   <= {1'b0, shift[7:1]};
                     bit_cnt <= bit_cnt + 3'd1;
                     tx_r    <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 8'd1;
               end
            end
            STOP: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  busy_r   <= 1'b0;
                  state    <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 8'd1;
               end
            end
            default: begin
               tx_r   <= 1'b1;
               busy_r <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.tx         = tx_r;
   assign bus.busy       = busy_r;
   assign bus.fifo_level = level;
   assign bus.overflow   = overflow_r;
endmodule

// File: doc/cipher_uart_tx.md
# cipher_uart_tx

Downstream serial egress stage for the keystream cipher core. It accepts one ciphertext byte per `in_valid` pulse and buffers bytes in a small FIFO. It drains the FIFO as 8N1 UART frames on a single pin, so encrypted traffic can leave the chip on one pad without host flow control. Dropped bytes are flagged by a sticky overflow bit that firmware clears.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; legal range 2..255.
- `DEPTH_LOG2`, 2: log2 of FIFO depth; FIFO depth = 4 by default.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_data` input 8: ciphertext byte from the cipher core.
- `in_valid` input 1: one-cycle write strobe for `in_data`; there is no backpressure.
- `clr_overflow` input 1: synchronous clear of `overflow`.
- `tx` output 1: UART serial line, idle high, registered.
- `busy` output 1: high whenever the transmit FSM is not in IDLE.
- `fifo_level` output DEPTH_LOG2+1: number of bytes held in the FIFO (0..depth).
- `overflow` output 1: sticky; set when a byte is dropped.

## Operation
- FIFO:
  - Circular buffer with read/write pointers and an occupancy count.
  - Pointers wrap modulo depth.
  - Write occurs when `in_valid`=1 and the FIFO is not full.
  - A write when full is discarded and sets `overflow`.
  - Simultaneous write and pop while full: the write is accepted and the level is unchanged.
  - Simultaneous write and pop while empty is impossible; a pop requires level>0 at the start of the cycle.
- Overflow flag:
  - `clr_overflow`=1 clears `overflow`.
  - If a drop occurs in the same cycle as a clear, the set wins.
- Transmit FSM states:
  - IDLE: `tx`=1. If level>0, pop the head into an 8-bit shift register, clear the bit counter and the baud counter, and go to START. Otherwise stay in IDLE.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `tx` = shift[0]. After CLKS_PER_BIT cycles, shift right and increment the bit counter. After 8 bits, go to STOP. Bits are sent LSB first.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1; the terminal count advances the bit.
- `busy` = (state != IDLE).
- The FSM always spends at least one cycle in IDLE between frames.
- No other inputs affect a frame once it has started.

## Timing
- Reset values (asserted asynchronously, effective immediately):
  - `tx`=1, `busy`=0, `fifo_level`=0, `overflow`=0.
  - State IDLE; pointers and counters 0; FIFO contents discarded.
- Reset mid-frame:
  - `tx` returns high at once and the frame is truncated.
  - No resumption after reset release.
- `fifo_level` updates on the edge that samples `in_valid`.
- Latency, with FIFO empty and FSM in IDLE:
  - `in_valid` sampled at edge 0; level=1 after edge 0.
  - Pop at edge 1; `busy`=1 and `tx`=0 after edge 1.
  - `tx` therefore falls 2 edges after the strobe edge.
- Frame length is 10·CLKS_PER_BIT cycles.
- Back-to-back frames repeat every 10·CLKS_PER_BIT+1 cycles.
- `overflow` is visible the cycle after the dropped write.

## Test plan
- Reset, idle: assert `rst` for 3 cycles, release, then wait 50 cycles -> `tx`=1, `busy`=0, `fifo_level`=0, `overflow`=0 throughout.
- Single byte, CLKS_PER_BIT=4: one `in_valid` with `in_data`=0xA5 ->
  - `tx` falls 2 edges later.
  - Bit sequence, each bit held 4 cycles: 0 | 1,0,1,0,0,1,0,1 | 1.
  - `busy` drops 40 cycles after it rose.
- Burst/overflow, CLKS_PER_BIT=4: `in_valid` on 6 consecutive cycles with 0x10..0x15 ->
  - 0x10 popped immediately; 0x11..0x14 fill the FIFO to level 4.
  - 0x15 dropped and `overflow`=1.
  - `tx` emits 0x10..0x14 in order, frame starts 41 cycles apart, then idles.
- Overflow clear race: with FIFO full, pulse `clr_overflow` on the same cycle as a dropped write -> `overflow` stays 1; a later `clr_overflow` alone -> 0.
- Full write + pop: fill to 4 and hold `in_valid` on the cycle the FSM pops from IDLE -> write accepted, level stays 4, no overflow, byte order preserved.
- Reset mid-frame: assert `rst` during DATA bit 3 of 0x3C -> `tx`=1 the same cycle, level 0. After release with no input, no further frames are sent.
